mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 158 +++++++++++++++
 tb/tb_mem_access_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit for the MEM stage: turns one EX/MEM request into a single
// Wishbone classic cycle, aligns store data into byte lanes and extends load
// data on the way back. Misaligned or undefined accesses complete with err_o
// set and never touch the bus.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ex_valid_i,
    input  logic                  ex_mem_read_i,
    input  logic                  ex_mem_write_i,
    input  logic [2:0]            ex_funct3_i,
    input  logic [ADDR_WIDTH-1:0] ex_addr_i,
    input  logic [DATA_WIDTH-1:0] ex_wdata_i,
    output logic                  mem_busy_o,
    output logic                  mem_done_o,
    output logic                  err_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    output logic [3:0]            wb_sel_o,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    input  logic                  wb_ack_i
);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t                state, state_nxt;
    logic                  req;
    logic                  is_store;
    logic [1:0]            off;
    logic                  legal;
    logic [3:0]            sel;
    logic [DATA_WIDTH-1:0] wdat;
    logic [2:0]            funct3_q;
    logic [1:0]            off_q;
    logic [DATA_WIDTH-1:0] rd_shift;
    logic [DATA_WIDTH-1:0] load_val;

    assign req      = ex_valid_i & (ex_mem_read_i | ex_mem_write_i);
    assign is_store = ex_mem_write_i;   // a write wins when both strobes are set
    assign off      = ex_addr_i[1:0];

    // Decode access size: legality, lane enables and lane-aligned store data.
    // Store data is masked to the access size first so unused lanes stay zero.
    always_comb begin
        legal = 1'b0;
        sel   = 4'b0000;
        wdat  = '0;
        case (ex_funct3_i)
            3'd0, 3'd4: begin
                legal = !(is_store && ex_funct3_i == 3'd4);
                sel   = 4'b0001 << off;
                wdat  = DATA_WIDTH'(ex_wdata_i[7:0]) << {off, 3'b000};
            end
            3'd1, 3'd5: begin
                legal = !off[0] && !(is_store && ex_funct3_i == 3'd5);
                sel   = 4'b0011 << off;
                wdat  = DATA_WIDTH'(ex_wdata_i[15:0]) << {off, 3'b000};
            end
            3'd2: begin
                legal = (off == 2'b00);
                sel   = 4'b1111;
                wdat  = ex_wdata_i;
            end
            default: legal = 1'b0;
        endcase
    end

    // Pick the addressed lane out of the returned word and extend it.
    always_comb begin
        rd_shift = wb_dat_i >> {off_q, 3'b000};
        case (funct3_q)
            3'd0:    load_val = {{(DATA_WIDTH-8){rd_shift[7]}}, rd_shift[7:0]};
            3'd1:    load_val = {{(DATA_WIDTH-16){rd_shift[15]}}, rd_shift[15:0]};
            3'd4:    load_val = {{(DATA_WIDTH-8){1'b0}}, rd_shift[7:0]};
            3'd5:    load_val = {{(DATA_WIDTH-16){1'b0}}, rd_shift[15:0]};
            default: load_val = wb_dat_i;
        endcase
    end

    // Next state and the combinational stall request.
    always_comb begin
        state_nxt  = state;
        mem_busy_o = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    mem_busy_o = 1'b1;
                    state_nxt  = legal ? BUS : DONE;
                end
            end
            BUS: begin
                mem_busy_o = 1'b1;
                if (wb_ack_i) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register, bus outputs, result capture and completion pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_we_o    <= 1'b0;
            wb_adr_o   <= '0;
            wb_dat_o   <= '0;
            wb_sel_o   <= 4'b0000;
            mem_data_o <= '0;
            mem_done_o <= 1'b0;
            err_o      <= 1'b0;
            funct3_q   <= 3'd0;
            off_q      <= 2'b00;
        end else begin
            state      <= state_nxt;
            mem_done_o <= 1'b0;
            err_o      <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        if (legal) begin
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                            wb_we_o  <= is_store;
                            wb_adr_o <= {ex_addr_i[ADDR_WIDTH-1:2], 2'b00};
                            wb_dat_o <= is_store ? wdat : '0;
                            wb_sel_o <= sel;
                            funct3_q <= ex_funct3_i;
                            off_q    <= off;
                        end else begin
                            err_o      <= 1'b1;
                            mem_done_o <= 1'b1;
                            mem_data_o <= '0;
                        end
                    end
                end
                BUS: begin
                    if (wb_ack_i) begin
                        wb_cyc_o   <= 1'b0;
                        wb_stb_o   <= 1'b0;
                        mem_done_o <= 1'b1;
                        if (!wb_we_o) mem_data_o <= load_val;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes the expected bus
// cycle and completion into queues; a monitor on the falling edge compares.
module tb_mem_access_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ex_valid_i, ex_mem_read_i, ex_mem_write_i;
    logic [2:0]  ex_funct3_i;
    logic [31:0] ex_addr_i, ex_wdata_i;
    logic        mem_busy_o, mem_done_o, err_o;
    logic [31:0] mem_data_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i;

    mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ex_valid_i(ex_valid_i), .ex_mem_read_i(ex_mem_read_i),
        .ex_mem_write_i(ex_mem_write_i), .ex_funct3_i(ex_funct3_i),
        .ex_addr_i(ex_addr_i), .ex_wdata_i(ex_wdata_i),
        .mem_busy_o(mem_busy_o), .mem_done_o(mem_done_o), .err_o(err_o),
        .mem_data_o(mem_data_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
    } bus_t;

    typedef struct {
        logic        err;
        logic [31:0] data;
    } done_t;

    bus_t  bus_q[$];
    done_t done_q[$];
    bus_t  mb;
    done_t md;
    int    n_pass = 0;
    int    n_total = 0;
    int    cyc_cycles = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic push_bus(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                            input logic [31:0] dat);
        bus_t b;
        b.we = we; b.adr = adr; b.sel = sel; b.dat = dat;
        bus_q.push_back(b);
    endtask

    task automatic push_done(input logic err, input logic [31:0] data);
        done_t d;
        d.err = err; d.data = data;
        done_q.push_back(d);
    endtask

    // Monitor: every active bus cycle must match the head expectation (so the
    // outputs are held through wait states); the ack retires it. Every done
    // pulse retires one completion expectation.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (wb_cyc_o) begin
                cyc_cycles++;
                if (bus_q.size() == 0) chk("unexpected_bus_cycle", 32'd1, 32'd0);
                else begin
                    mb = bus_q[0];
                    chk("wb_stb", {31'd0, wb_stb_o}, 32'd1);
                    chk("wb_we",  {31'd0, wb_we_o}, {31'd0, mb.we});
                    chk("wb_adr", wb_adr_o, mb.adr);
                    chk("wb_sel", {28'd0, wb_sel_o}, {28'd0, mb.sel});
                    chk("wb_dat", wb_dat_o, mb.dat);
                    if (wb_ack_i) void'(bus_q.pop_front());
                end
            end
            if (mem_done_o) begin
                if (done_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
                else begin
                    md = done_q.pop_front();
                    chk("err_o", {31'd0, err_o}, {31'd0, md.err});
                    chk("mem_data_o", mem_data_o, md.data);
                end
            end else if (err_o) begin
                chk("err_without_done", 32'd1, 32'd0);
            end
        end
    end

    // Issue one request from a cycle start (posedge + 1) and act as the slave.
    task automatic do_req(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rdat, input int waits, input bit legal,
                          output int busy);
        int got;
        busy = 0;
        ex_valid_i = 1'b1; ex_mem_read_i = rd; ex_mem_write_i = wr;
        ex_funct3_i = f3; ex_addr_i = a; ex_wdata_i = wd;
        @(negedge clk_i); if (mem_busy_o) busy++;
        @(posedge clk_i); #1;
        ex_valid_i = 1'b0; ex_mem_read_i = 1'b0; ex_mem_write_i = 1'b0;
        if (legal) begin
            for (int i = 0; i < waits; i++) begin
                @(negedge clk_i); if (mem_busy_o) busy++;
                @(posedge clk_i); #1;
            end
            wb_ack_i = 1'b1; wb_dat_i = rdat;
            @(negedge clk_i); if (mem_busy_o) busy++;
            @(posedge clk_i); #1;
            wb_ack_i = 1'b0; wb_dat_i = 32'h0;
        end
        got = 0;
        for (int i = 0; i < 8 && got == 0; i++) begin
            @(negedge clk_i);
            if (mem_busy_o) busy++;
            if (mem_done_o) got = 1;
            @(posedge clk_i); #1;
        end
        chk("done_seen", got, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy;
        int cyc0;
        rst_i = 1'b1; ex_valid_i = 1'b0; ex_mem_read_i = 1'b0; ex_mem_write_i = 1'b0;
        ex_funct3_i = 3'd0; ex_addr_i = 32'h0; ex_wdata_i = 32'h0;
        wb_dat_i = 32'h0; wb_ack_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;

        // Reset state
        @(negedge clk_i);
        chk("rst_cyc",  {31'd0, wb_cyc_o}, 32'd0);
        chk("rst_stb",  {31'd0, wb_stb_o}, 32'd0);
        chk("rst_we",   {31'd0, wb_we_o}, 32'd0);
        chk("rst_adr",  wb_adr_o, 32'd0);
        chk("rst_dat",  wb_dat_o, 32'd0);
        chk("rst_sel",  {28'd0, wb_sel_o}, 32'd0);
        chk("rst_data", mem_data_o, 32'd0);
        chk("rst_done", {31'd0, mem_done_o}, 32'd0);
        chk("rst_err",  {31'd0, err_o}, 32'd0);
        chk("rst_busy", {31'd0, mem_busy_o}, 32'd0);
        @(posedge clk_i); #1;

        // Valid without read/write is not a request; ack in IDLE is ignored
        ex_valid_i = 1'b1;
        @(negedge clk_i); chk("noreq_busy", {31'd0, mem_busy_o}, 32'd0);
        @(posedge clk_i); #1; ex_valid_i = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'h12345678;
        @(posedge clk_i); #1; wb_ack_i = 1'b0; wb_dat_i = 32'h0;
        @(negedge clk_i); chk("idle_ack_data", mem_data_o, 32'd0);
        @(posedge clk_i); #1;

        // LW, two wait states
        push_bus(1'b0, 32'h80000104, 4'b1111, 32'h0);
        push_done(1'b0, 32'hDEADBEEF);
        do_req(1'b1, 1'b0, 3'd2, 32'h80000104, 32'h0, 32'hDEADBEEF, 2, 1'b1, busy);
        chk("lw_busy_cycles", busy, 32'd4);

        // LB / LBU on the top byte
        push_bus(1'b0, 32'h80000000, 4'b1000, 32'h0);
        push_done(1'b0, 32'hFFFFFF80);
        do_req(1'b1, 1'b0, 3'd0, 32'h80000003, 32'h0, 32'h80FF1234, 0, 1'b1, busy);
        chk("lb_busy_cycles", busy, 32'd2);
        push_bus(1'b0, 32'h80000000, 4'b1000, 32'h0);
        push_done(1'b0, 32'h00000080);
        do_req(1'b1, 1'b0, 3'd4, 32'h80000003, 32'h0, 32'h80FF1234, 1, 1'b1, busy);

        // SH into the upper half; load result is left unchanged
        push_bus(1'b1, 32'h80000000, 4'b1100, 32'hABCD0000);
        push_done(1'b0, 32'h00000080);
        do_req(1'b0, 1'b1, 3'd1, 32'h80000002, 32'h0000ABCD, 32'hFFFFFFFF, 0, 1'b1, busy);

        // LH sign-extended from upper half, LHU zero-extended from lower half
        push_bus(1'b0, 32'h80000000, 4'b1100, 32'h0);
        push_done(1'b0, 32'hFFFF8001);
        do_req(1'b1, 1'b0, 3'd1, 32'h80000002, 32'h0, 32'h80017FFF, 0, 1'b1, busy);
        push_bus(1'b0, 32'h80000000, 4'b0011, 32'h0);
        push_done(1'b0, 32'h0000F00D);
        do_req(1'b1, 1'b0, 3'd5, 32'h80000000, 32'h0, 32'h8001F00D, 0, 1'b1, busy);

        // SB to lane 1; upper store-data bits must not leak
        push_bus(1'b1, 32'h80000000, 4'b0010, 32'h0000DD00);
        push_done(1'b0, 32'h0000F00D);
        do_req(1'b0, 1'b1, 3'd0, 32'h80000001, 32'hAABBCCDD, 32'h0, 1, 1'b1, busy);

        // Reset in BUS together with ack: no completion, result cleared
        push_bus(1'b0, 32'h80000020, 4'b1111, 32'h0);
        ex_valid_i = 1'b1; ex_mem_read_i = 1'b1; ex_funct3_i = 3'd2; ex_addr_i = 32'h80000020;
        @(posedge clk_i); #1;
        ex_valid_i = 1'b0; ex_mem_read_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b1; wb_ack_i = 1'b1; wb_dat_i = 32'hCAFEF00D;
        @(posedge clk_i); #1;
        rst_i = 1'b0; wb_ack_i = 1'b0; wb_dat_i = 32'h0;
        bus_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("rstbus_cyc",  {31'd0, wb_cyc_o}, 32'd0);
            chk("rstbus_stb",  {31'd0, wb_stb_o}, 32'd0);
            chk("rstbus_done", {31'd0, mem_done_o}, 32'd0);
            chk("rstbus_busy", {31'd0, mem_busy_o}, 32'd0);
            chk("rstbus_data", mem_data_o, 32'd0);
            @(posedge clk_i); #1;
        end

        // Both strobes high: the store wins
        push_bus(1'b1, 32'h80000010, 4'b1111, 32'h12345678);
        push_done(1'b0, 32'h0);
        do_req(1'b1, 1'b1, 3'd2, 32'h80000010, 32'h12345678, 32'h0, 0, 1'b1, busy);

        // Put a nonzero result in place before the error cases
        push_bus(1'b0, 32'h80000008, 4'b1111, 32'h0);
        push_done(1'b0, 32'h5A5A5A5A);
        do_req(1'b1, 1'b0, 3'd2, 32'h80000008, 32'h0, 32'h5A5A5A5A, 0, 1'b1, busy);

        // Illegal accesses: error completion, no bus cycle, result zeroed
        cyc0 = cyc_cycles;
        push_done(1'b1, 32'h0);
        do_req(1'b1, 1'b0, 3'd2, 32'h80000006, 32'h0, 32'h0, 0, 1'b0, busy);
        chk("lw_mis_busy", busy, 32'd1);
        push_done(1'b1, 32'h0);
        do_req(1'b1, 1'b0, 3'd1, 32'h80000001, 32'h0, 32'h0, 0, 1'b0, busy);
        push_done(1'b1, 32'h0);
        do_req(1'b1, 1'b0, 3'd3, 32'h80000000, 32'h0, 32'h0, 0, 1'b0, busy);
        push_done(1'b1, 32'h0);
        do_req(1'b0, 1'b1, 3'd4, 32'h80000000, 32'h0, 32'h0, 0, 1'b0, busy);
        push_done(1'b1, 32'h0);
        do_req(1'b0, 1'b1, 3'd2, 32'h80000002, 32'h0, 32'h0, 0, 1'b0, busy);
        chk("illegal_no_cyc", cyc_cycles - cyc0, 32'd0);

        repeat (3) @(posedge clk_i);
        chk("bus_q_drained", bus_q.size(), 32'd0);
        chk("done_q_drained", done_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
